// File: rtl/mult_operand_feeder.sv
`timescale 1ns/1ps
// mult_operand_feeder: FIFO-buffered operand issuer for the 4-bit sequential multiplier.
// Define MULT_FEEDER_STATS_EN to add the issued_cnt operation counter output.
module mult_operand_feeder #(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_x,
  input  logic [WIDTH-1:0]       in_y,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       mul_x,
  output logic [WIDTH-1:0]       mul_y,
  output logic                   mul_start,
  input  logic                   mul_ready,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   timeout_err
`ifdef MULT_FEEDER_STATS_EN
  ,
  output logic [15:0]            issued_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  // Watchdog counts 0..TIMEOUT_CYCLES-1 while waiting.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                 state_q, state_d;
  logic [LvlW-1:0]        level_q, level_d;
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        wdog_q, wdog_d;
  logic                   err_q, err_d;
  logic [WIDTH-1:0]       mul_x_q, mul_y_q;
  logic [2*WIDTH-1:0]     mem_q [DEPTH];
  logic                   push, pop;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign in_ready = (level_q != LvlW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == StIdle) && (level_q != '0);

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (pop) state_d = StIssue;
      end
      StIssue: begin
        state_d = StWait;
        wdog_d  = '0;
      end
      StWait: begin
        if (mul_ready) begin
          state_d = StIdle;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (wdog_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else begin
            wdog_d = wdog_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= StIdle;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
      mul_x_q  <= '0;
      mul_y_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        mul_x_q  <= mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
        mul_y_q  <= mem_q[rd_ptr_q][WIDTH-1:0];
      end
    end
  end

  // Storage needs no reset; only entries below level are ever read.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= {in_x, in_y};
  end

  assign mul_x       = mul_x_q;
  assign mul_y       = mul_y_q;
  assign mul_start   = (state_q == StIssue);
  assign busy        = (state_q != StIdle);
  assign level       = level_q;
  assign timeout_err = err_q;

`ifdef MULT_FEEDER_STATS_EN
  logic [15:0] issued_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      issued_q <= '0;
    end else if (mul_start) begin
      issued_q <= issued_q + 16'd1;
    end
  end

  assign issued_cnt = issued_q;
`endif

  level_bound_a : assert property (@(posedge clk_in) disable iff (!rst_in)
    level_q <= LvlW'(DEPTH));
  start_pulse_a : assert property (@(posedge clk_in) disable iff (!rst_in)
    mul_start |=> !mul_start);

endmodule

// File: tb/tb_mult_operand_feeder.sv
`timescale 1ns/1ps
// Bench for mult_operand_feeder: queue-based cycle model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mult_operand_feeder;

  localparam int unsigned WIDTH          = 4;
  localparam int unsigned DEPTH          = 4;
  localparam int unsigned TIMEOUT_CYCLES = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_x, in_y;
  logic             in_ready;
  logic [WIDTH-1:0] mul_x, mul_y;
  logic             mul_start;
  logic             mul_ready;
  logic             busy;
  logic [2:0]       level;
  logic             timeout_err;
`ifdef MULT_FEEDER_STATS_EN
  logic [15:0]      issued_cnt;
`endif

  mult_operand_feeder #(
    .WIDTH          (WIDTH),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .in_valid    (in_valid),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_ready    (in_ready),
    .mul_x       (mul_x),
    .mul_y       (mul_y),
    .mul_start   (mul_start),
    .mul_ready   (mul_ready),
    .busy        (busy),
    .level       (level),
    .timeout_err (timeout_err)
`ifdef MULT_FEEDER_STATS_EN
    ,
    .issued_cnt  (issued_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: pending pairs as a queue; op_phase 0=idle, 1=start cycle, 2=awaiting ready.
  int q_x[$];
  int q_y[$];
  int m_x = 0, m_y = 0, op_phase = 0, waited = 0, m_cnt = 0;
  bit m_err = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        q_x.delete();
        q_y.delete();
        m_x = 0; m_y = 0; op_phase = 0; waited = 0; m_cnt = 0; m_err = 1'b0;
      end else begin
        int  prev;
        bit  do_push, do_pop;
        prev    = op_phase;
        do_push = in_valid && (q_x.size() != DEPTH);
        do_pop  = (prev == 0) && (q_x.size() != 0);
        if (do_pop) begin
          m_x = q_x.pop_front();
          m_y = q_y.pop_front();
          op_phase = 1;
        end
        if (do_push) begin
          q_x.push_back(int'(in_x));
          q_y.push_back(int'(in_y));
        end
        if (prev == 1) begin
          op_phase = 2;
          waited   = 0;
          m_cnt    = (m_cnt + 1) % 65536;
        end else if (prev == 2) begin
          waited++;
          if (mul_ready) begin
            op_phase = 0;
          end else if (TIMEOUT_CYCLES != 0 && waited == TIMEOUT_CYCLES) begin
            op_phase = 0;
            m_err    = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("m_level", int'(level), q_x.size());
        check("m_in_ready", int'(in_ready), int'(q_x.size() != DEPTH));
        check("m_mul_start", int'(mul_start), int'(op_phase == 1));
        check("m_busy", int'(busy), int'(op_phase != 0));
        check("m_mul_x", int'(mul_x), m_x);
        check("m_mul_y", int'(mul_y), m_y);
        check("m_timeout_err", int'(timeout_err), int'(m_err));
`ifdef MULT_FEEDER_STATS_EN
        check("m_issued_cnt", int'(issued_cnt), m_cnt);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int t4_x[3] = '{1, 3, 5};
  int t4_y[3] = '{2, 4, 6};

  initial begin
    int rdy_at;
    int seen;
    rst = 1'b0; in_valid = 1'b1; in_x = 4'd7; in_y = 4'd0; mul_ready = 1'b0;

    // Reset held with a pending offer: nothing enters the FIFO.
    for (int c = 0; c < 2; c++) begin
      step();
      model_on = 1'b1;
      @(negedge clk);
      check("rst_level", int'(level), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_mul_start", int'(mul_start), 0);
      check("rst_mul_x", int'(mul_x), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_timeout_err", int'(timeout_err), 0);
    end
    step();
    rst = 1'b1; in_valid = 1'b0;

    // Single op: push (3,5) in cycle 0, ready in cycle 6.
    for (int c = 0; c < 8; c++) begin
      step();
      in_valid = (c == 0); in_x = 4'd3; in_y = 4'd5; mul_ready = (c == 6);
      @(negedge clk);
      if (c == 1) check("t2_level_c1", int'(level), 1);
      if (c == 2) begin
        check("t2_start_c2", int'(mul_start), 1);
        check("t2_mul_x", int'(mul_x), 3);
        check("t2_mul_y", int'(mul_y), 5);
      end else begin
        check("t2_no_start", int'(mul_start), 0);
      end
      if (c >= 3 && c <= 6) check("t2_busy_wait", int'(busy), 1);
      if (c == 7) check("t2_idle_c7", int'(busy), 0);
    end

    // Fill to full with no ready, then the watchdog abandons the first op.
    for (int c = 0; c < 22; c++) begin
      step();
      in_valid = (c <= 5); in_x = 4'(9 + c); in_y = 4'(2 * c + 2); mul_ready = 1'b0;
      @(negedge clk);
      if (c == 5) begin
        check("t3_full_in_ready", int'(in_ready), 0);
        check("t3_full_level", int'(level), 4);
      end
      if (c == 6) check("t3_drop_level", int'(level), 4);
      if (c == 18) begin
        check("t5_busy_c18", int'(busy), 1);
        check("t5_err_c18", int'(timeout_err), 0);
      end
      if (c == 19) begin
        check("t5_idle_c19", int'(busy), 0);
        check("t5_err_c19", int'(timeout_err), 1);
        check("t5_level_c19", int'(level), 4);
      end
      if (c == 20) begin
        check("t5_next_start", int'(mul_start), 1);
        check("t5_next_x", int'(mul_x), 10);
        check("t5_next_y", int'(mul_y), 4);
        check("t5_next_level", int'(level), 3);
        check("t5_err_sticky", int'(timeout_err), 1);
      end
    end

    // Reset mid-operation clears everything, including the sticky error.
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rst2_err", int'(timeout_err), 0);
    check("rst2_level", int'(level), 0);
    check("rst2_busy", int'(busy), 0);
    check("rst2_mul_x", int'(mul_x), 0);

    // Three queued ops, each answered three cycles after its start.
    rdy_at = -1;
    seen   = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      in_valid = (c < 3); in_x = 4'(2 * c + 1); in_y = 4'(2 * c + 2);
      mul_ready = (c == rdy_at);
      @(negedge clk);
      if (mul_start) begin
        if (seen < 3) begin
          check("t4_order_x", int'(mul_x), t4_x[seen]);
          check("t4_order_y", int'(mul_y), t4_y[seen]);
        end
        rdy_at = c + 3;
        seen++;
      end
    end
    check("t4_issued", seen, 3);
    check("t4_level_end", int'(level), 0);
    check("t4_busy_end", int'(busy), 0);
`ifdef MULT_FEEDER_STATS_EN
    check("t6_issued_cnt", int'(issued_cnt), 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
